// File: rtl/div_result_bcd.sv
// Converts a divider quotient/remainder pair to BCD with double-dabble, one bit per cycle,
// and drives registered BCD plus active-low 7-segment patterns (dashes on divide-by-zero).
module div_result_bcd #(
    parameter int Nbits  = 5,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Nbits-1:0]      quotient,
    input  logic [Nbits-1:0]      remainder,
    input  logic                  div_zero,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic [7*DIGITS-1:0]   q_seg,
    output logic [7*DIGITS-1:0]   r_seg,
    output logic                  err,
    output logic                  out_valid
);

    // state | meaning
    // IDLE  | waiting for a pair, in_ready high
    // SHIFT | double-dabble in progress, one input bit per cycle
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int CW = $clog2(Nbits + 1);
    localparam int AW = 4 * DIGITS;

    state_t          state;
    logic [Nbits-1:0] q_sh, r_sh;
    logic [AW-1:0]   q_acc, r_acc;
    logic [AW-1:0]   q_adj, r_adj, q_acc_nx, r_acc_nx;
    logic [CW-1:0]   cnt;
    logic            dz;
    logic            blank;

    function automatic logic [AW-1:0] add3(input logic [AW-1:0] a);
        logic [AW-1:0] o;
        o = a;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                o[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return o;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign q_adj    = add3(q_acc);
    assign r_adj    = add3(r_acc);
    assign q_acc_nx = (q_adj << 1) | {{(AW-1){1'b0}}, q_sh[Nbits-1]};
    assign r_acc_nx = (r_adj << 1) | {{(AW-1){1'b0}}, r_sh[Nbits-1]};

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q_sh      <= '0;
            r_sh      <= '0;
            q_acc     <= '0;
            r_acc     <= '0;
            cnt       <= '0;
            dz        <= 1'b0;
            q_bcd     <= '0;
            r_bcd     <= '0;
            err       <= 1'b0;
            blank     <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_sh  <= quotient;
                        r_sh  <= remainder;
                        dz    <= div_zero;
                        q_acc <= '0;
                        r_acc <= '0;
                        cnt   <= CW'(Nbits);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    q_acc <= q_acc_nx;
                    r_acc <= r_acc_nx;
                    q_sh  <= q_sh << 1;
                    r_sh  <= r_sh << 1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        // Divide-by-zero results are forced to zero so the BCD never shows garbage.
                        q_bcd     <= dz ? '0 : q_acc_nx;
                        r_bcd     <= dz ? '0 : r_acc_nx;
                        err       <= dz;
                        blank     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        q_seg = '1;
        r_seg = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (blank) begin
                q_seg[7*i +: 7] = 7'b1111111;
                r_seg[7*i +: 7] = 7'b1111111;
            end else if (err) begin
                q_seg[7*i +: 7] = 7'b0111111;
                r_seg[7*i +: 7] = 7'b0111111;
            end else begin
                q_seg[7*i +: 7] = seg7(q_bcd[4*i +: 4]);
                r_seg[7*i +: 7] = seg7(r_bcd[4*i +: 4]);
            end
        end
    end

endmodule
